// File: rtl/oss_hal_avmm_bridge.sv
// Avalon-MM slave front-end for the HAL reg_itf: it turns host reads and writes into single-cycle
// reg_itf pulses, merges partial writes by read-modify-write, and flags out-of-range or conflicting requests.
//
// state     | meaning
// IDLE      | ready, avs_waitrequest low
// RD_ISSUE  | reg_itf read pulse
// RD_WAIT   | wait RD_LATENCY cycles for HAL data
// RD_RESP   | load out-of-range read response
// WR_ISSUE  | reg_itf write pulse, full word
// RMW_ISSUE | reg_itf read pulse for partial write
// RMW_WAIT  | wait RD_LATENCY cycles for old word
// RMW_WRITE | reg_itf write pulse with merged word
module oss_hal_avmm_bridge #(
    parameter int          AVS_ADDR_W  = 6,
    parameter int          RD_LATENCY  = 1,
    parameter logic [31:0] DECERR_DATA = 32'hDEAD_BEEF
) (
    input  logic                  hal_clk,
    input  logic                  hal_reset,
    input  logic [AVS_ADDR_W-1:0] avs_address,
    input  logic                  avs_read,
    input  logic                  avs_write,
    input  logic [31:0]           avs_writedata,
    input  logic [3:0]            avs_byteenable,
    output logic                  avs_waitrequest,
    output logic [31:0]           avs_readdata,
    output logic                  avs_readdatavalid,
    output logic                  reg_itf_read_out,
    output logic                  reg_itf_write_out,
    output logic [3:0]            reg_itf_addr_out,
    output logic [31:0]           reg_itf_writedata_out,
    input  logic [31:0]           reg_itf_readdata_in,
    input  logic                  err_clear_in,
    output logic                  err_out,
    output logic [15:0]           txn_count_out
);

    typedef enum logic [2:0] {
        IDLE, RD_ISSUE, RD_WAIT, RD_RESP, WR_ISSUE, RMW_ISSUE, RMW_WAIT, RMW_WRITE
    } state_t;

    localparam logic [2:0] WAIT_LOAD = 3'(RD_LATENCY - 1);

    state_t      state, next_state;
    logic [2:0]  wait_cnt;
    logic [31:0] cap_wdata;
    logic [3:0]  cap_be;
    logic        accept, dec_err;
    logic        load_cnt, resp_hal, resp_decerr, rmw_capture, txn_done, err_set;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                                input logic [31:0] new_w,
                                                input logic [3:0]  be);
        logic [31:0] m;
        m = old_w;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) m[8*i +: 8] = new_w[8*i +: 8];
        end
        return m;
    endfunction

    generate
        if (AVS_ADDR_W > 4) begin : g_hi_bits
            assign dec_err = |avs_address[AVS_ADDR_W-1:4];
        end else begin : g_no_hi_bits
            assign dec_err = 1'b0;
        end
    endgenerate

    assign accept          = (state == IDLE) && (avs_read || avs_write);
    assign avs_waitrequest = hal_reset || (state != IDLE);

    always_comb begin
        next_state  = state;
        load_cnt    = 1'b0;
        resp_hal    = 1'b0;
        resp_decerr = 1'b0;
        rmw_capture = 1'b0;
        txn_done    = 1'b0;
        err_set     = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    // A write wins over a simultaneous read; the read is flagged and dropped.
                    if (avs_write) begin
                        err_set = dec_err || avs_read;
                        if (dec_err || (avs_byteenable == 4'b0000)) txn_done = 1'b1;
                        else if (avs_byteenable == 4'b1111)         next_state = WR_ISSUE;
                        else                                        next_state = RMW_ISSUE;
                    end else if (dec_err) begin
                        err_set    = 1'b1;
                        next_state = RD_RESP;
                    end else begin
                        next_state = RD_ISSUE;
                    end
                end
            end
            RD_ISSUE: begin
                next_state = RD_WAIT;
                load_cnt   = 1'b1;
            end
            RD_WAIT: begin
                if (wait_cnt == 3'd0) begin
                    next_state = IDLE;
                    resp_hal   = 1'b1;
                    txn_done   = 1'b1;
                end
            end
            RD_RESP: begin
                next_state  = IDLE;
                resp_decerr = 1'b1;
                txn_done    = 1'b1;
            end
            WR_ISSUE: begin
                next_state = IDLE;
                txn_done   = 1'b1;
            end
            RMW_ISSUE: begin
                next_state = RMW_WAIT;
                load_cnt   = 1'b1;
            end
            RMW_WAIT: begin
                if (wait_cnt == 3'd0) begin
                    next_state  = RMW_WRITE;
                    rmw_capture = 1'b1;
                end
            end
            RMW_WRITE: begin
                next_state = IDLE;
                txn_done   = 1'b1;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge hal_clk or posedge hal_reset) begin
        if (hal_reset) begin
            state                 <= IDLE;
            wait_cnt              <= 3'd0;
            cap_wdata             <= 32'd0;
            cap_be                <= 4'd0;
            avs_readdata          <= 32'd0;
            avs_readdatavalid     <= 1'b0;
            reg_itf_read_out      <= 1'b0;
            reg_itf_write_out     <= 1'b0;
            reg_itf_addr_out      <= 4'd0;
            reg_itf_writedata_out <= 32'd0;
            err_out               <= 1'b0;
            txn_count_out         <= 16'd0;
        end else begin
            state             <= next_state;
            reg_itf_read_out  <= (next_state == RD_ISSUE) || (next_state == RMW_ISSUE);
            reg_itf_write_out <= (next_state == WR_ISSUE) || (next_state == RMW_WRITE);
            avs_readdatavalid <= resp_hal || resp_decerr;

            if (accept) begin
                cap_wdata <= avs_writedata;
                cap_be    <= avs_byteenable;
            end
            if (accept && (next_state == RD_ISSUE || next_state == WR_ISSUE ||
                           next_state == RMW_ISSUE)) begin
                reg_itf_addr_out <= avs_address[3:0];
            end
            if (accept && (next_state == WR_ISSUE)) begin
                reg_itf_writedata_out <= avs_writedata;
            end else if (rmw_capture) begin
                reg_itf_writedata_out <= merge_bytes(reg_itf_readdata_in, cap_wdata, cap_be);
            end

            if (load_cnt) begin
                wait_cnt <= WAIT_LOAD;
            end else if ((state == RD_WAIT || state == RMW_WAIT) && (wait_cnt != 3'd0)) begin
                wait_cnt <= wait_cnt - 3'd1;
            end

            if (resp_hal)         avs_readdata <= reg_itf_readdata_in;
            else if (resp_decerr) avs_readdata <= DECERR_DATA;

            if (txn_done) txn_count_out <= txn_count_out + 16'd1;

            if (err_set)           err_out <= 1'b1;
            else if (err_clear_in) err_out <= 1'b0;
        end
    end

endmodule

// File: tb/tb_oss_hal_avmm_bridge.sv
// Scoreboard bench for oss_hal_avmm_bridge: instance 0 uses RD_LATENCY=1, instance 1 uses RD_LATENCY=3,
// each paired with a small HAL register-file model.
`timescale 1ns/1ps
module tb_oss_hal_avmm_bridge;

    logic hal_clk = 1'b0;
    always #5 hal_clk = ~hal_clk;

    int cyc = 0;
    always @(posedge hal_clk) cyc <= cyc + 1;

    logic        rst      [2];
    logic [5:0]  a_addr   [2];
    logic        a_read   [2];
    logic        a_write  [2];
    logic [31:0] a_wdata  [2];
    logic [3:0]  a_be     [2];
    logic        wreq     [2];
    logic [31:0] rdata    [2];
    logic        rvalid   [2];
    logic        rd_o     [2];
    logic        wr_o     [2];
    logic [3:0]  addr_o   [2];
    logic [31:0] wdata_o  [2];
    logic [31:0] hal_rd   [2];
    logic        e_clr    [2];
    logic        err      [2];
    logic [15:0] cnt      [2];

    oss_hal_avmm_bridge #(.AVS_ADDR_W(6), .RD_LATENCY(1), .DECERR_DATA(32'hDEAD_BEEF)) u_dut0 (
        .hal_clk(hal_clk), .hal_reset(rst[0]), .avs_address(a_addr[0]), .avs_read(a_read[0]),
        .avs_write(a_write[0]), .avs_writedata(a_wdata[0]), .avs_byteenable(a_be[0]),
        .avs_waitrequest(wreq[0]), .avs_readdata(rdata[0]), .avs_readdatavalid(rvalid[0]),
        .reg_itf_read_out(rd_o[0]), .reg_itf_write_out(wr_o[0]), .reg_itf_addr_out(addr_o[0]),
        .reg_itf_writedata_out(wdata_o[0]), .reg_itf_readdata_in(hal_rd[0]),
        .err_clear_in(e_clr[0]), .err_out(err[0]), .txn_count_out(cnt[0]));

    oss_hal_avmm_bridge #(.AVS_ADDR_W(6), .RD_LATENCY(3), .DECERR_DATA(32'hDEAD_BEEF)) u_dut1 (
        .hal_clk(hal_clk), .hal_reset(rst[1]), .avs_address(a_addr[1]), .avs_read(a_read[1]),
        .avs_write(a_write[1]), .avs_writedata(a_wdata[1]), .avs_byteenable(a_be[1]),
        .avs_waitrequest(wreq[1]), .avs_readdata(rdata[1]), .avs_readdatavalid(rvalid[1]),
        .reg_itf_read_out(rd_o[1]), .reg_itf_write_out(wr_o[1]), .reg_itf_addr_out(addr_o[1]),
        .reg_itf_writedata_out(wdata_o[1]), .reg_itf_readdata_in(hal_rd[1]),
        .err_clear_in(e_clr[1]), .err_out(err[1]), .txn_count_out(cnt[1]));

    // HAL model: register file with a read pipeline; the tap sets the read latency.
    logic        hal_load;
    logic [31:0] mem  [2][16];
    logic [31:0] pipe [2][3];
    assign hal_rd[0] = pipe[0][0];
    assign hal_rd[1] = pipe[1][2];

    always @(posedge hal_clk) begin
        for (int s = 0; s < 2; s++) begin
            pipe[s][0] <= rd_o[s] ? mem[s][addr_o[s]] : 32'h0BAD_0BAD;
            pipe[s][1] <= pipe[s][0];
            pipe[s][2] <= pipe[s][1];
            if (hal_load) begin
                for (int i = 0; i < 16; i++)
                    mem[s][i] <= ((s == 0) ? 32'h5A5A_0000 : 32'h3C3C_0000) | 32'(i);
            end else if (wr_o[s]) begin
                mem[s][addr_o[s]] <= wdata_o[s];
            end
        end
    end

    typedef struct {
        int          s;
        logic [3:0]  addr;
        logic [31:0] data;
        int          off;
    } exp_t;

    exp_t q_rp[$];
    exp_t q_wp[$];
    exp_t q_rv[$];
    int   last_acc [2];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, required 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic exp_rp(input int s, input logic [3:0] a, input int off);
        q_rp.push_back('{s: s, addr: a, data: 32'd0, off: off});
    endtask

    task automatic exp_wp(input int s, input logic [3:0] a, input logic [31:0] d, input int off);
        q_wp.push_back('{s: s, addr: a, data: d, off: off});
    endtask

    task automatic exp_rv(input int s, input logic [31:0] d, input int off);
        q_rv.push_back('{s: s, addr: 4'd0, data: d, off: off});
    endtask

    // Drives one host request until the bridge accepts it; last_acc holds the acceptance edge.
    task automatic host(input int s, input bit rd, input bit wr, input logic [5:0] a,
                        input logic [31:0] d, input logic [3:0] be, input bit clr);
        int n;
        @(negedge hal_clk);
        a_read[s] = rd; a_write[s] = wr; a_addr[s] = a; a_wdata[s] = d; a_be[s] = be; e_clr[s] = clr;
        n = 0;
        while (wreq[s] && n < 50) begin
            @(negedge hal_clk);
            n++;
        end
        chk("accept_within_budget", 32'(n < 50), 32'd1);
        @(posedge hal_clk);
        last_acc[s] = cyc + 1;
        @(negedge hal_clk);
        a_read[s] = 1'b0; a_write[s] = 1'b0; e_clr[s] = 1'b0;
    endtask

    task automatic clear_err(input int s);
        @(negedge hal_clk);
        e_clr[s] = 1'b1;
        @(negedge hal_clk);
        e_clr[s] = 1'b0;
        chk("err_cleared", 32'(err[s]), 32'd0);
    endtask

    task automatic check_reset_outputs(input int s);
        chk("rst_waitrequest", 32'(wreq[s]), 32'd1);
        chk("rst_readdatavalid", 32'(rvalid[s]), 32'd0);
        chk("rst_readdata", rdata[s], 32'd0);
        chk("rst_rd_pulse", 32'(rd_o[s]), 32'd0);
        chk("rst_wr_pulse", 32'(wr_o[s]), 32'd0);
        chk("rst_addr", 32'(addr_o[s]), 32'd0);
        chk("rst_wdata", wdata_o[s], 32'd0);
        chk("rst_err", 32'(err[s]), 32'd0);
        chk("rst_count", 32'(cnt[s]), 32'd0);
    endtask

    // Monitor: every reg_itf pulse and readdatavalid must match the head of its queue.
    bit   prev_rd [2];
    bit   prev_wr [2];
    bit   prev_rv [2];
    exp_t mon_e;

    initial begin
        forever begin
            @(negedge hal_clk);
            for (int s = 0; s < 2; s++) begin
                if (rst[s] !== 1'b0) begin
                    prev_rd[s] = 1'b0; prev_wr[s] = 1'b0; prev_rv[s] = 1'b0;
                end else begin
                    if (rd_o[s] && wr_o[s]) chk("rd_wr_exclusive", 32'd1, 32'd0);
                    if (rd_o[s]) begin
                        chk("rd_pulse_single", 32'(prev_rd[s]), 32'd0);
                        chk("rd_pulse_expected", 32'(q_rp.size() != 0), 32'd1);
                        if (q_rp.size() != 0) begin
                            mon_e = q_rp.pop_front();
                            chk("rd_pulse_inst", 32'(s), 32'(mon_e.s));
                            chk("rd_pulse_addr", 32'(addr_o[s]), 32'(mon_e.addr));
                            chk("rd_pulse_cycle", cyc, last_acc[s] + mon_e.off);
                        end
                    end
                    if (wr_o[s]) begin
                        chk("wr_pulse_single", 32'(prev_wr[s]), 32'd0);
                        chk("wr_pulse_expected", 32'(q_wp.size() != 0), 32'd1);
                        if (q_wp.size() != 0) begin
                            mon_e = q_wp.pop_front();
                            chk("wr_pulse_inst", 32'(s), 32'(mon_e.s));
                            chk("wr_pulse_addr", 32'(addr_o[s]), 32'(mon_e.addr));
                            chk("wr_pulse_data", wdata_o[s], mon_e.data);
                            chk("wr_pulse_cycle", cyc, last_acc[s] + mon_e.off);
                        end
                    end
                    if (rvalid[s]) begin
                        chk("rdv_single", 32'(prev_rv[s]), 32'd0);
                        chk("rdv_expected", 32'(q_rv.size() != 0), 32'd1);
                        if (q_rv.size() != 0) begin
                            mon_e = q_rv.pop_front();
                            chk("rdv_inst", 32'(s), 32'(mon_e.s));
                            chk("rdv_data", rdata[s], mon_e.data);
                            chk("rdv_cycle", cyc, last_acc[s] + mon_e.off);
                        end
                    end
                    prev_rd[s] = rd_o[s]; prev_wr[s] = wr_o[s]; prev_rv[s] = rvalid[s];
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d failures %0d", n_chk, n_fail);
        $fatal(1, "watchdog");
    end

    int acc_a;

    initial begin
        hal_load = 1'b1;
        for (int s = 0; s < 2; s++) begin
            rst[s] = 1'b1; a_addr[s] = 6'd0; a_read[s] = 1'b0; a_write[s] = 1'b0;
            a_wdata[s] = 32'd0; a_be[s] = 4'd0; e_clr[s] = 1'b0; last_acc[s] = 0;
        end
        repeat (3) @(negedge hal_clk);
        hal_load = 1'b0;
        check_reset_outputs(0);
        rst[0] = 1'b0; rst[1] = 1'b0;
        #1;
        chk("idle_waitrequest", 32'(wreq[0]), 32'd0);

        // Full writes, then two back-to-back reads.
        exp_wp(0, 4'd0, 32'h0000_0005, 0);
        host(0, 0, 1, 6'd0, 32'h0000_0005, 4'hF, 0);
        exp_wp(0, 4'd1, 32'h0000_0003, 0);
        host(0, 0, 1, 6'd1, 32'h0000_0003, 4'hF, 0);
        exp_rp(0, 4'd2, 0); exp_rv(0, 32'h5A5A_0002, 2);
        host(0, 1, 0, 6'd2, 32'd0, 4'h0, 0);
        acc_a = last_acc[0];
        chk("count_after_3", 32'(cnt[0]), 32'd2);
        exp_rp(0, 4'd2, 0); exp_rv(0, 32'h5A5A_0002, 2);
        host(0, 1, 0, 6'd2, 32'd0, 4'h0, 0);
        chk("b2b_accept_edge", last_acc[0], acc_a + 3);
        repeat (5) @(negedge hal_clk);
        chk("count_4", 32'(cnt[0]), 32'd4);
        chk("err_clean", 32'(err[0]), 32'd0);
        chk("readdata_hold", rdata[0], 32'h5A5A_0002);

        // Partial write by read-modify-write.
        exp_wp(0, 4'd0, 32'h1122_3344, 0);
        host(0, 0, 1, 6'd0, 32'h1122_3344, 4'hF, 0);
        exp_rp(0, 4'd0, 0); exp_wp(0, 4'd0, 32'h11BB_33DD, 2);
        host(0, 0, 1, 6'd0, 32'hAABB_CCDD, 4'b0101, 0);
        exp_rp(0, 4'd0, 0); exp_rv(0, 32'h11BB_33DD, 2);
        host(0, 1, 0, 6'd0, 32'd0, 4'h0, 0);
        repeat (5) @(negedge hal_clk);
        chk("count_7", 32'(cnt[0]), 32'd7);

        // Out-of-range read.
        exp_rv(0, 32'hDEAD_BEEF, 1);
        host(0, 1, 0, 6'h10, 32'd0, 4'h0, 0);
        repeat (4) @(negedge hal_clk);
        chk("decerr_read_err", 32'(err[0]), 32'd1);
        chk("count_8", 32'(cnt[0]), 32'd8);
        clear_err(0);

        // Read and write together: write wins, read dropped, error flagged.
        exp_wp(0, 4'd1, 32'h0000_0007, 0);
        host(0, 1, 1, 6'd1, 32'h0000_0007, 4'hF, 0);
        repeat (4) @(negedge hal_clk);
        chk("rw_conflict_err", 32'(err[0]), 32'd1);
        chk("count_9", 32'(cnt[0]), 32'd9);
        exp_rp(0, 4'd1, 0); exp_rv(0, 32'h0000_0007, 2);
        host(0, 1, 0, 6'd1, 32'd0, 4'h0, 0);
        repeat (4) @(negedge hal_clk);
        chk("count_10", 32'(cnt[0]), 32'd10);
        clear_err(0);

        // Byteenable 0000: counted, silent, no error.
        host(0, 0, 1, 6'd3, 32'hFFFF_FFFF, 4'b0000, 0);
        repeat (3) @(negedge hal_clk);
        chk("be0_err", 32'(err[0]), 32'd0);
        chk("count_11", 32'(cnt[0]), 32'd11);
        exp_rp(0, 4'd3, 0); exp_rv(0, 32'h5A5A_0003, 2);
        host(0, 1, 0, 6'd3, 32'd0, 4'h0, 0);
        repeat (4) @(negedge hal_clk);
        chk("count_12", 32'(cnt[0]), 32'd12);

        // Out-of-range write with clear in the same cycle: set wins.
        host(0, 0, 1, 6'h25, 32'h0000_0001, 4'hF, 1);
        repeat (3) @(negedge hal_clk);
        chk("set_beats_clear", 32'(err[0]), 32'd1);
        chk("count_13", 32'(cnt[0]), 32'd13);

        // Reset while in RD_WAIT: transaction abandoned.
        exp_rp(0, 4'd0, 0);
        host(0, 1, 0, 6'd0, 32'd0, 4'h0, 0);
        @(negedge hal_clk);
        rst[0] = 1'b1;
        #1;
        check_reset_outputs(0);
        repeat (2) @(negedge hal_clk);
        chk("rst_held_waitrequest", 32'(wreq[0]), 32'd1);
        chk("rst_held_rdv", 32'(rvalid[0]), 32'd0);
        rst[0] = 1'b0;
        repeat (6) @(negedge hal_clk);
        chk("count_after_abandon", 32'(cnt[0]), 32'd0);
        exp_rp(0, 4'd0, 0); exp_rv(0, 32'h11BB_33DD, 2);
        host(0, 1, 0, 6'd0, 32'd0, 4'h0, 0);
        repeat (4) @(negedge hal_clk);
        chk("count_after_reset_read", 32'(cnt[0]), 32'd1);

        // RD_LATENCY=3 instance.
        exp_rp(1, 4'd0, 0); exp_rv(1, 32'h3C3C_0000, 4);
        host(1, 1, 0, 6'd0, 32'd0, 4'h0, 0);
        for (int k = 0; k < 4; k++) begin
            chk("lat3_waitrequest_busy", 32'(wreq[1]), 32'd1);
            @(negedge hal_clk);
        end
        chk("lat3_waitrequest_idle", 32'(wreq[1]), 32'd0);
        repeat (3) @(negedge hal_clk);
        chk("lat3_count", 32'(cnt[1]), 32'd1);

        for (int n = 0; n < 20 && (q_rp.size() + q_wp.size() + q_rv.size()) != 0; n++)
            @(negedge hal_clk);
        chk("expectations_drained", 32'(q_rp.size() + q_wp.size() + q_rv.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
